// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter in front of one shared
// unsigned eq/lt/gt compare stage with tagged, held results.
//
// Ports:
//   clk, rst      rising-edge clock, sync active-high reset
//   req_valid     per-requester request valid (NREQ bits)
//   req_ready     one-hot grant, combinational in IDLE
//   req_a, req_b  packed operands, slice i = [i*WIDTH +: WIDTH]
//   rsp_valid     result valid, held until rsp_ready
//   rsp_ready     consumer accepts the result
//   rsp_id        requester index of the result
//   rsp_eq/lt/gt  registered compare flags
module cmp_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 20,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_eq,
  output logic                  rsp_lt,
  output logic                  rsp_gt
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  op_id_q, op_id_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_eq_q, rsp_eq_d;
  logic             rsp_lt_q, rsp_lt_d;
  logic             rsp_gt_q, rsp_gt_d;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             cmp_eq;
  logic             cmp_lt;

  // Scan from ptr upward, wrapping; first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grant_vld)
      req_ready[grant_idx] = 1'b1;
  end

  // The single shared comparator; gt is derived.
  assign cmp_eq = (op_a_q == op_b_q);
  assign cmp_lt = (op_a_q < op_b_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_id_d     = op_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_eq_d    = rsp_eq_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_gt_d    = rsp_gt_q;
    if (rst) begin
      state_d     = IDLE;
      ptr_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = '0;
      rsp_eq_d    = 1'b0;
      rsp_lt_d    = 1'b0;
      rsp_gt_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_vld) begin
            op_a_d  = req_a[grant_idx*WIDTH +: WIDTH];
            op_b_d  = req_b[grant_idx*WIDTH +: WIDTH];
            op_id_d = grant_idx;
            state_d = CMP;
          end
        end
        CMP: begin
          rsp_eq_d    = cmp_eq;
          rsp_lt_d    = cmp_lt;
          rsp_gt_d    = !cmp_eq && !cmp_lt;
          rsp_id_d    = op_id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            // Next search starts just past the served requester.
            if (rsp_id_q == ID_W'(NREQ - 1))
              ptr_d = '0;
            else
              ptr_d = rsp_id_q + ID_W'(1);
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    ptr_q       <= ptr_d;
    op_id_q     <= op_id_d;
    op_a_q      <= op_a_d;
    op_b_q      <= op_b_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_id_q    <= rsp_id_d;
    rsp_eq_q    <= rsp_eq_d;
    rsp_lt_q    <= rsp_lt_d;
    rsp_gt_q    <= rsp_gt_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_eq    = rsp_eq_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_gt    = rsp_gt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed and random stimulus against a
// transaction-level reference model of the arbiter.
module tb_cmp_arbiter;
  localparam int N  = 4;
  localparam int W  = 20;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic           rsp_eq;
  logic           rsp_lt;
  logic           rsp_gt;

  always #5 clk = ~clk;

  cmp_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .rsp_gt    (rsp_gt)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driven values, applied each cycle.
  logic         drv_rst;
  logic [N-1:0] drv_v;
  logic [W-1:0] drv_a [N];
  logic [W-1:0] drv_b [N];
  logic         drv_rr;

  // Model: age<0 idle, 0 accepted, >=1 result visible.
  int           m_age   = -1;
  int           m_ptr   = 0;
  bit           m_known = 0;
  int           m_id;
  logic [W-1:0] m_a, m_b;
  int           v_id = 0;
  bit           v_eq = 0, v_lt = 0, v_gt = 0;
  int           granted = -1;

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic cycle();
    int g;
    int best;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    rst       = drv_rst;
    rsp_ready = drv_rr;
    req_valid = drv_v;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = drv_a[i];
      req_b[i*W +: W] = drv_b[i];
    end
    #1;
    // Grantee: valid requester at smallest distance past ptr.
    g = -1;
    best = N;
    for (int i = 0; i < N; i++)
      if (drv_v[i] && ((i - m_ptr + N) % N) < best) begin
        best = (i - m_ptr + N) % N;
        g = i;
      end
    exp_ready = '0;
    granted = -1;
    if (!drv_rst && m_age < 0 && g >= 0) begin
      exp_ready = N'(1) << g;
      granted = g;
    end
    chk("req_ready", req_ready, exp_ready);
    if (m_known) begin
      chk("rsp_valid", rsp_valid, m_age >= 1);
      chk("rsp_id", rsp_id, v_id);
      chk("rsp_eq", rsp_eq, v_eq);
      chk("rsp_lt", rsp_lt, v_lt);
      chk("rsp_gt", rsp_gt, v_gt);
    end
    if (drv_rst) begin
      m_age = -1; m_ptr = 0; m_known = 1;
      v_id = 0; v_eq = 0; v_lt = 0; v_gt = 0;
    end else if (m_age < 0) begin
      if (g >= 0) begin
        m_id = g; m_a = drv_a[g]; m_b = drv_b[g]; m_age = 0;
      end
    end else if (m_age == 0) begin
      v_id = m_id;
      v_eq = (m_a == m_b);
      v_lt = (m_a < m_b);
      v_gt = (m_a > m_b);
      m_age = 1;
    end else if (drv_rr) begin
      m_age = -1;
      m_ptr = (v_id + 1) % N;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    drv_rst = 1'b1;
    drv_v   = v;
    repeat (2) cycle();
    drv_rst = 1'b0;
  endtask

  task automatic drain();
    drv_v  = '0;
    drv_rr = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic one_cmp(input string tag, input int id,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit e_eq, input bit e_lt, input bit e_gt);
    bit seen = 0;
    drv_v = N'(1) << id;
    drv_a[id] = a;
    drv_b[id] = b;
    drv_rr = 1'b1;
    cycle();
    drv_v = '0;
    repeat (4) begin
      cycle();
      if (!seen && rsp_valid) begin
        seen = 1;
        chk({tag, "_eq"}, rsp_eq, e_eq);
        chk({tag, "_lt"}, rsp_lt, e_lt);
        chk({tag, "_gt"}, rsp_gt, e_gt);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return 20'hFFFFF;
      3: return 20'h80000;
      4: return 20'h7FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  int gq[$];
  int tq[$];
  int exp_rr [6] = '{0, 1, 2, 3, 0, 1};
  bit pend [N];

  initial begin
    drv_rr = 1'b1;
    for (int i = 0; i < N; i++) begin
      drv_a[i] = '0;
      drv_b[i] = '0;
    end

    // Reset with all requesters valid, then round-robin order.
    drv_rst = 1'b1;
    drv_v   = 4'b1111;
    cycle();
    chk("rst_ready0", req_ready, 0);
    cycle();
    chk("rst_ready1", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_flags", {rsp_eq, rsp_lt, rsp_gt}, 0);
    drv_rst = 1'b0;
    for (int c = 0; c < 18; c++) begin
      cycle();
      if (req_ready != 0) begin
        gq.push_back(idx_of(req_ready));
        tq.push_back(c);
      end
    end
    chk("rr_count", gq.size(), 6);
    chk("rr_first_t", tq.size() > 0 ? tq[0] : -1, 0);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      chk("rr_order", gq[i], exp_rr[i]);
    for (int i = 1; i < tq.size(); i++)
      chk("rr_spacing", tq[i] - tq[i-1], 3);
    drain();

    // Single request from requester 2.
    do_reset('0);
    drv_v = 4'b0100;
    drv_a[2] = 20'h00010;
    drv_b[2] = 20'h00020;
    cycle();
    chk("single_grant", req_ready, 4'b0100);
    drv_v = '0;
    cycle();
    cycle();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    chk("single_flags", {rsp_eq, rsp_lt, rsp_gt}, 3'b010);
    drv_v = 4'b1000;
    cycle();
    chk("single_idle", req_ready, 4'b1000);
    drain();

    // Unsigned compare boundaries.
    one_cmp("b_max", 0, 20'hFFFFF, 20'hFFFFF, 1, 0, 0);
    one_cmp("b_gt0", 1, 20'hFFFFF, 20'h00000, 0, 0, 1);
    one_cmp("b_lt1", 2, 20'h00000, 20'h00001, 0, 1, 0);
    one_cmp("b_msb", 3, 20'h80000, 20'h7FFFF, 0, 0, 1);

    // Response backpressure with requesters 1 and 3.
    do_reset('0);
    drv_v = 4'b1010;
    drv_a[1] = 20'h5; drv_b[1] = 20'h5;
    drv_rr = 1'b0;
    cycle();
    chk("bp_grant", req_ready, 4'b0010);
    cycle();
    cycle();
    chk("bp_valid0", rsp_valid, 1);
    repeat (5) begin
      cycle();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_flags", {rsp_eq, rsp_lt, rsp_gt}, 3'b100);
      chk("bp_ready", req_ready, 0);
    end
    drv_rr = 1'b1;
    cycle();
    cycle();
    chk("bp_next", req_ready, 4'b1000);
    drain();

    // Reset while in CMP.
    do_reset('0);
    drv_v = 4'b0100;
    cycle();
    drv_v = '0;
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    repeat (3) begin
      cycle();
      chk("rc_valid", rsp_valid, 0);
      chk("rc_flags", {rsp_id, rsp_eq, rsp_lt, rsp_gt}, 0);
    end

    // Reset while in RESP with backpressure.
    drv_v = 4'b0100;
    drv_rr = 1'b0;
    cycle();
    drv_v = '0;
    cycle();
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    cycle();
    chk("rr_valid", rsp_valid, 0);
    chk("rr_flags", {rsp_id, rsp_eq, rsp_lt, rsp_gt}, 0);
    drv_v = 4'b1111;
    drv_rr = 1'b1;
    cycle();
    chk("rr_ptr0", req_ready, 4'b0001);
    drain();

    // Random traffic.
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (granted == i) pend[i] = 0;
        if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 0;
        end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          drv_a[i] = pick();
          drv_b[i] = ($urandom_range(0, 2) == 0) ? drv_a[i] : pick();
        end
        drv_v[i] = pend[i];
      end
      drv_rr  = ($urandom_range(0, 3) != 0);
      drv_rst = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
